// File: rtl/uart_result_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_result_tx
// Description : Return path of the UART ALU. Takes one N-bit signed ALU
//               result on a valid/ready handshake and serializes it onto the
//               TX line as N/8 back-to-back 8N1 frames, least-significant
//               byte first, LSB first within each byte. Raw two's-complement
//               bits are sent.
// Ports       : clk          - system clock, all logic on rising edge
//               rst_n        - synchronous active-low reset
//               result_in    - N-bit result, sampled only on accept
//               result_valid - result_in valid this cycle
//               result_ready - block can accept a result (state is IDLE)
//               tx           - UART serial line, idle high, registered
//               busy         - transmission in progress (state not IDLE)
//               done         - one-cycle pulse at end of the last stop bit
// Revision    : 1.0 - initial release
// ============================================================================
module uart_result_tx #(
    parameter int N            = 16,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] result_in,
    input  logic         result_valid,
    output logic         result_ready,
    output logic         tx,
    output logic         busy,
    output logic         done
);

    localparam int BYTES  = N / 8;
    localparam int CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int BYTE_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    localparam logic [CNT_W-1:0]  c_BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BYTE_W-1:0] c_BYTE_LAST = BYTE_W'(BYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_baud;
    logic [2:0]        r_bit;
    logic [BYTE_W-1:0] r_byte;
    logic [N-1:0]      r_shift;
    logic              r_tx;
    logic              r_done;

    logic              w_bit_end;
    logic [2:0]        w_next_bit;

    assign w_bit_end  = (r_baud == c_BAUD_LAST);
    assign w_next_bit = r_bit + 3'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_byte  <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_tx <= 1'b1;
                    // result_ready is high in IDLE, so valid alone accepts.
                    if (result_valid) begin
                        r_shift <= result_in;
                        r_byte  <= '0;
                        r_baud  <= '0;
                        r_tx    <= 1'b0;
                        r_state <= S_START;
                    end
                end

                S_START: begin
                    if (w_bit_end) begin
                        r_baud  <= '0;
                        r_bit   <= '0;
                        r_tx    <= r_shift[0];
                        r_state <= S_DATA;
                    end else begin
                        r_baud <= r_baud + CNT_W'(1);
                    end
                end

                S_DATA: begin
                    if (w_bit_end) begin
                        r_baud <= '0;
                        if (r_bit == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            // Present the next bit in the same edge that ends
                            // the current one so the line never glitches.
                            r_bit <= w_next_bit;
                            r_tx  <= r_shift[w_next_bit];
                        end
                    end else begin
                        r_baud <= r_baud + CNT_W'(1);
                    end
                end

                S_STOP: begin
                    if (w_bit_end) begin
                        r_baud <= '0;
                        if (r_byte == c_BYTE_LAST) begin
                            r_done  <= 1'b1;
                            r_tx    <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            // Next byte follows with no idle gap.
                            r_byte  <= r_byte + BYTE_W'(1);
                            r_shift <= r_shift >> 8;
                            r_tx    <= 1'b0;
                            r_state <= S_START;
                        end
                    end else begin
                        r_baud <= r_baud + CNT_W'(1);
                    end
                end

                default: begin
                    r_tx    <= 1'b1;
                    r_baud  <= '0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign tx           = r_tx;
    assign done         = r_done;
    assign busy         = (r_state != S_IDLE);
    assign result_ready = (r_state == S_IDLE);

endmodule
`default_nettype wire

// File: doc/uart_result_tx.md
# uart_result_tx

Serializes one N-bit signed ALU result (shift, add, logic unit output) onto the UART TX line as N/8 standard 8N1 frames, least-significant byte first. It sits between the ALU result mux and the board TX pin and is the return path of the UART ALU: operands arrive over the UART receiver, results leave through this block. It uses a simple valid/ready handshake on the ALU side and a one-cycle completion pulse.

## Interface

- N, 16, result width in bits; must be a multiple of 8 and ≥ 8
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); must be ≥ 2
- clk  input  1  system clock; all logic on rising edge
- rst_n  input  1  synchronous, active-low reset
- result_in  input  N  signed ALU result to transmit; sampled only on accept
- result_valid  input  1  result_in is valid this cycle
- result_ready  output  1  block can accept a result this cycle
- tx  output  1  UART serial line, idle high
- busy  output  1  a transmission is in progress
- done  output  1  one-cycle pulse when the last stop bit of the last byte completes

## Operation

- Accept: result_valid && result_ready at a rising edge. result_in is latched into an internal N-bit shift register; the byte counter is cleared.
- result_valid while result_ready=0 is ignored; no queueing, and a later change of result_in does not affect the frame in flight.
- State machine (registered):
  - IDLE: tx=1, result_ready=1, busy=0. On accept → START.
  - START: tx=0 for CLKS_PER_BIT cycles → DATA, bit index=0.
  - DATA: tx = bit [bit index] of current byte (shift-register LSB), each held CLKS_PER_BIT cycles; after bit 7 → STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At the end, if byte counter < N/8−1: increment, shift register right by 8 → START. Otherwise pulse done → IDLE.
- Byte order: result_in[7:0] first, result_in[N−1:N−8] last. Bit order within a byte: LSB first. The sign bit has no special treatment; raw two's-complement bits are sent.
- Baud counter counts 0..CLKS_PER_BIT−1 and wraps to 0 on each bit boundary. It is cleared on every state entry.
- busy = (state != IDLE); result_ready = (state == IDLE).
- tx is a registered output (no combinational glitches).

## Timing

- Reset values: tx=1, result_ready=1, busy=0, done=0, state=IDLE, counters=0.
- Reset mid-frame: on the next edge with rst_n=0, tx returns to 1 and all state is cleared. No done pulse is issued, and a partial frame is abandoned.
- Accept at edge k: tx=0 and busy=1 are visible after edge k; result_ready=0 is visible after edge k.
- Each bit lasts exactly CLKS_PER_BIT cycles. Each byte lasts 10·CLKS_PER_BIT cycles. There is no idle gap between bytes of one result.
- Total latency from accept edge to done high: (N/8)·10·CLKS_PER_BIT cycles. done is high for exactly one cycle, in the same cycle the state returns to IDLE.
- In the done cycle, result_ready=1 and tx=1. An accept in that cycle starts the next START immediately. The minimum stop-to-start gap between results is 1 cycle.
- Simultaneous rst_n=0 and result_valid=1: reset wins, and nothing is latched.

## Test plan

Use N=16 and CLKS_PER_BIT=4 unless noted.

- Reset: hold rst_n=0 for 3 cycles with result_valid=1 → tx=1, result_ready=1, busy=0, done=0 throughout; no frame starts after release until a new accept.
- Single result 16'hA55A → the line carries start, bits 0,1,0,1,1,0,1,0 (0x5A LSB-first), stop, then start, bits 1,0,1,0,0,1,0,1 (0xA5), stop. Each bit lasts 4 cycles. done pulses once, exactly 80 cycles after the accept edge.
- Negative value −2 (16'hFFFE) → bytes 0xFE then 0xFF are decoded by a bench UART monitor; the decoded 16-bit value is −2.
- Back-to-back: assert result_valid continuously with 16'h0001, then 16'h8000 → the second accept occurs in the done cycle of the first. The results are separated by exactly 1 idle-high cycle, and the decoded byte stream is 01 00 00 80.
- Ignore-while-busy: pulse result_valid with 16'h1234 during the DATA state of a 16'h00FF transfer → only bytes FF 00 appear, and a single done pulse is issued.
- Reset mid-frame: assert rst_n=0 during bit 3 of byte 1 → tx=1 on the next edge, busy=0, no done pulse. A new accept of 16'h00C3 afterwards transmits correctly. Repeat with N=8, CLKS_PER_BIT=2, value 8'h81 → one frame, done at 20 cycles.
